// File: rtl/capture_sequencer_pkg.sv
// rtl/capture_sequencer_pkg.sv - state encodings and width helper for the capture sequencer
package capture_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  // Bits needed to hold value, never less than one.
  function automatic int bits_for(input int value);
    int w;
    w = 1;
    while ((1 << w) <= value) w++;
    return w;
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - control, sample strobe and capture status bundle
interface capture_sequencer_if #(
  parameter int DELAY_WIDTH  = 16,
  parameter int LENGTH_WIDTH = 16
);
  import capture_sequencer_pkg::*;

  logic [DELAY_WIDTH-1:0]  cfg_delay;
  logic [LENGTH_WIDTH-1:0] cfg_length;
  logic                    arm;
  logic                    trigger;
  logic                    abort;
  logic                    s_valid;
  logic                    capture_en;
  logic [LENGTH_WIDTH-1:0] sample_index;
  logic                    busy;
  logic                    done;
  logic [STATE_W-1:0]      state;

  modport master (
    output cfg_delay, cfg_length, arm, trigger, abort, s_valid,
    input  capture_en, sample_index, busy, done, state
  );

  modport slave (
    input  cfg_delay, cfg_length, arm, trigger, abort, s_valid,
    output capture_en, sample_index, busy, done, state
  );

endinterface

// File: rtl/capture_sequencer_seq_count.sv
// rtl/capture_sequencer_seq_count.sv - up-counter with sync clear, enable and terminal compare
module seq_count #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - arm/trigger controller gating a sample stream into a capture window
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int DELAY_WIDTH  = 16,
  parameter int LENGTH_WIDTH = 16,
  parameter int HOLDOFF      = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  capture_sequencer_if.slave   bus
);

  localparam int CNT_W  = (DELAY_WIDTH > LENGTH_WIDTH) ? DELAY_WIDTH : LENGTH_WIDTH;
  localparam int HOLD_W = bits_for(HOLDOFF);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_t                  state, state_next;
  logic [DELAY_WIDTH-1:0]  delay_q;
  logic [LENGTH_WIDTH-1:0] length_q;
  logic                    load_cfg;
  logic                    done_set;
  logic                    busy_q;
  logic                    done_q;

  logic [CNT_W-1:0]        smp_count;
  logic [CNT_W-1:0]        smp_limit;
  logic                    smp_last;
  logic                    smp_clr;
  logic                    smp_en;
  logic                    counting;

  logic [HOLD_W-1:0]       hold_count;
  logic                    hold_last;
  logic                    hold_clr;

  assign counting  = (state == S_DELAY) || (state == S_CAPTURE);
  assign smp_limit = (state == S_DELAY) ? (CNT_W'(delay_q) - CNT_W'(1))
                                        : (CNT_W'(length_q) - CNT_W'(1));
  assign smp_en    = bus.s_valid && counting;
  // Any state change (including abort) restarts the sample count for the next phase.
  assign smp_clr   = (state_next != state) || !counting;
  assign hold_clr  = (state != S_HOLDOFF) || (state_next != S_HOLDOFF);

  seq_count #(.WIDTH(CNT_W)) u_sample_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (smp_clr),
    .en       (smp_en),
    .limit    (smp_limit),
    .count    (smp_count),
    .at_limit (smp_last)
  );

  seq_count #(.WIDTH(HOLD_W)) u_holdoff_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (hold_clr),
    .en       (1'b1),
    .limit    (HOLD_LIMIT),
    .count    (hold_count),
    .at_limit (hold_last)
  );

  always_comb begin
    state_next = state;
    load_cfg   = 1'b0;
    done_set   = 1'b0;
    if (bus.abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.arm && (bus.cfg_length != '0)) begin
            state_next = S_ARMED;
            load_cfg   = 1'b1;
          end
        end
        S_ARMED: begin
          if (bus.trigger) state_next = (delay_q != '0) ? S_DELAY : S_CAPTURE;
        end
        S_DELAY: begin
          if (bus.s_valid && smp_last) state_next = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (bus.s_valid && smp_last) begin
            state_next = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
            done_set   = 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (hold_last) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      delay_q  <= '0;
      length_q <= '0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != S_IDLE);
      done_q <= done_set;
      if (load_cfg) begin
        delay_q  <= bus.cfg_delay;
        length_q <= bus.cfg_length;
      end
    end
  end

  // Write enable is decoded from registered state so it lines up with the strobe cycle.
  assign bus.capture_en   = (state == S_CAPTURE) && bus.s_valid;
  assign bus.sample_index = smp_count[LENGTH_WIDTH-1:0];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.state        = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - directed bench for capture_sequencer (HOLDOFF=15 and HOLDOFF=0 builds)
module tb_capture_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  capture_sequencer_if #(.DELAY_WIDTH(16), .LENGTH_WIDTH(16)) ifa ();
  capture_sequencer_if #(.DELAY_WIDTH(16), .LENGTH_WIDTH(16)) ifb ();

  capture_sequencer #(.DELAY_WIDTH(16), .LENGTH_WIDTH(16), .HOLDOFF(15)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  capture_sequencer #(.DELAY_WIDTH(16), .LENGTH_WIDTH(16), .HOLDOFF(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.cfg_delay = '0; ifa.cfg_length = '0; ifa.arm = 0; ifa.trigger = 0; ifa.abort = 0; ifa.s_valid = 0;
    ifb.cfg_delay = '0; ifb.cfg_length = '0; ifb.arm = 0; ifb.trigger = 0; ifb.abort = 0; ifb.s_valid = 0;
    tick();
    tick();
    chk("rst_state", ifa.state, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_cap", ifa.capture_en, 0);
    chk("rst_idx", ifa.sample_index, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_state", ifa.state, 0);

    // Basic capture, delay 0, length 4
    ifa.cfg_length = 4; ifa.cfg_delay = 0; ifa.arm = 1;
    tick();
    ifa.arm = 0;
    chk("t1_armed", ifa.state, 1);
    chk("t1_busy", ifa.busy, 1);
    ifa.trigger = 1; ifa.s_valid = 1;
    #1;
    chk("t1_trig_cap", ifa.capture_en, 0);
    tick();
    ifa.trigger = 0;
    chk("t1_capture", ifa.state, 3);
    for (int i = 0; i < 4; i++) begin
      chk("t1_cap_en", ifa.capture_en, 1);
      chk("t1_idx", ifa.sample_index, i);
      chk("t1_nodone", ifa.done, 0);
      tick();
    end
    ifa.s_valid = 0;
    #1;
    chk("t1_holdoff", ifa.state, 4);
    chk("t1_done", ifa.done, 1);
    chk("t1_cap_off", ifa.capture_en, 0);
    for (int k = 1; k < 15; k++) begin
      tick();
      chk("t1_hold_state", ifa.state, 4);
      chk("t1_hold_busy", ifa.busy, 1);
      if (k == 1) chk("t1_done_once", ifa.done, 0);
    end
    tick();
    chk("t1_idle", ifa.state, 0);
    chk("t1_idle_busy", ifa.busy, 0);

    // Delay 3, length 2, strobes every other cycle; arm/trigger ignored in HOLDOFF
    ifa.cfg_delay = 3; ifa.cfg_length = 2; ifa.arm = 1;
    tick();
    ifa.arm = 0; ifa.trigger = 1;
    tick();
    ifa.trigger = 0;
    chk("t2_delay", ifa.state, 2);
    for (int n = 1; n <= 5; n++) begin
      ifa.s_valid = 1;
      #1;
      chk("t2_cap_en", ifa.capture_en, (n >= 4) ? 1 : 0);
      chk("t2_state", ifa.state, (n >= 4) ? 3 : 2);
      if (n >= 4) chk("t2_idx", ifa.sample_index, n - 4);
      tick();
      ifa.s_valid = 0;
      if (n < 5) tick();
    end
    chk("t2_done", ifa.done, 1);
    chk("t2_holdoff", ifa.state, 4);
    ifa.arm = 1; ifa.trigger = 1; ifa.cfg_length = 4;
    tick();
    ifa.arm = 0; ifa.trigger = 0;
    chk("t4_hold_ignore", ifa.state, 4);
    chk("t2_done_once", ifa.done, 0);
    repeat (13) tick();
    chk("t2_hold_last", ifa.state, 4);
    tick();
    chk("t2_idle", ifa.state, 0);

    // Abort mid-capture, then restart at index 0
    ifa.cfg_delay = 0; ifa.cfg_length = 8; ifa.arm = 1;
    tick();
    ifa.arm = 0; ifa.trigger = 1;
    tick();
    ifa.trigger = 0; ifa.s_valid = 1;
    #1;
    chk("t3_capture", ifa.state, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_cap_en", ifa.capture_en, 1);
      chk("t3_idx", ifa.sample_index, i);
      tick();
    end
    ifa.s_valid = 0; ifa.abort = 1;
    tick();
    ifa.abort = 0;
    chk("t3_abort_state", ifa.state, 0);
    chk("t3_abort_busy", ifa.busy, 0);
    chk("t3_abort_done", ifa.done, 0);
    chk("t3_abort_idx", ifa.sample_index, 0);
    ifa.s_valid = 1;
    #1;
    chk("t3_abort_cap", ifa.capture_en, 0);
    tick();
    chk("t3_no_done", ifa.done, 0);
    chk("t3_still_idle", ifa.state, 0);
    ifa.s_valid = 0; ifa.arm = 1;
    tick();
    ifa.arm = 0; ifa.trigger = 1;
    tick();
    ifa.trigger = 0; ifa.s_valid = 1;
    #1;
    chk("t3_re_state", ifa.state, 3);
    chk("t3_re_cap", ifa.capture_en, 1);
    chk("t3_re_idx0", ifa.sample_index, 0);
    tick();
    chk("t3_re_idx1", ifa.sample_index, 1);
    ifa.s_valid = 0; ifa.abort = 1;
    tick();
    ifa.abort = 0;
    chk("t3_re_abort", ifa.state, 0);

    // Ignored events: trigger in IDLE, zero-length arm, arm/trigger during CAPTURE
    ifa.trigger = 1;
    tick();
    ifa.trigger = 0;
    chk("t4_trig_idle", ifa.state, 0);
    ifa.cfg_length = 0; ifa.arm = 1;
    tick();
    ifa.arm = 0;
    chk("t4_len0_state", ifa.state, 0);
    chk("t4_len0_busy", ifa.busy, 0);
    ifa.cfg_length = 4; ifa.cfg_delay = 0; ifa.arm = 1;
    tick();
    ifa.arm = 0; ifa.trigger = 1;
    tick();
    chk("t4_capture", ifa.state, 3);
    ifa.arm = 1; ifa.trigger = 1; ifa.cfg_length = 2; ifa.s_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_cap_en", ifa.capture_en, 1);
      chk("t4_idx", ifa.sample_index, i);
      chk("t4_state", ifa.state, 3);
      tick();
    end
    chk("t4_holdoff", ifa.state, 4);
    chk("t4_done", ifa.done, 1);
    ifa.s_valid = 0; ifa.arm = 0; ifa.trigger = 0; ifa.abort = 1;
    tick();
    ifa.abort = 0;
    chk("t4_abort_hold", ifa.state, 0);

    // Asynchronous reset between edges during DELAY
    ifa.cfg_delay = 5; ifa.cfg_length = 2; ifa.arm = 1;
    tick();
    ifa.arm = 0; ifa.trigger = 1;
    tick();
    ifa.trigger = 0;
    chk("t5_delay", ifa.state, 2);
    ifa.s_valid = 1;
    tick();
    chk("t5_delay2", ifa.state, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_state", ifa.state, 0);
    chk("t5_rst_busy", ifa.busy, 0);
    chk("t5_rst_done", ifa.done, 0);
    chk("t5_rst_cap", ifa.capture_en, 0);
    chk("t5_rst_idx", ifa.sample_index, 0);
    ifa.s_valid = 0;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_after_rst", ifa.state, 0);

    // Abort wins over trigger in ARMED
    ifa.cfg_length = 3; ifa.cfg_delay = 0; ifa.arm = 1;
    tick();
    ifa.arm = 0;
    chk("t6_armed", ifa.state, 1);
    ifa.trigger = 1; ifa.abort = 1;
    tick();
    ifa.trigger = 0; ifa.abort = 0;
    chk("t6_abort_wins", ifa.state, 0);
    chk("t6_busy", ifa.busy, 0);

    // HOLDOFF=0 build: CAPTURE goes straight to IDLE, done still pulses
    ifb.cfg_length = 2; ifb.cfg_delay = 1; ifb.arm = 1;
    tick();
    ifb.arm = 0;
    chk("b_armed", ifb.state, 1);
    ifb.trigger = 1;
    tick();
    ifb.trigger = 0;
    chk("b_delay", ifb.state, 2);
    ifb.s_valid = 1;
    #1;
    chk("b_delay_cap", ifb.capture_en, 0);
    tick();
    chk("b_capture", ifb.state, 3);
    chk("b_cap0", ifb.capture_en, 1);
    chk("b_idx0", ifb.sample_index, 0);
    tick();
    chk("b_cap1", ifb.capture_en, 1);
    chk("b_idx1", ifb.sample_index, 1);
    tick();
    chk("b_idle", ifb.state, 0);
    chk("b_done", ifb.done, 1);
    chk("b_busy", ifb.busy, 0);
    ifb.s_valid = 0;
    tick();
    chk("b_done_once", ifb.done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Arm/trigger controller that gates a sample stream into a capture window: optional pre-trigger delay, fixed-length capture, then a holdoff before re-arming.
- Sits between the RF sample path (strobe `s_valid`) and the capture buffer writer.
- Drives the write-enable and write index.
- All counts in DELAY and CAPTURE advance on sample strobes; HOLDOFF counts clock cycles.

Parameters:
- DELAY_WIDTH, 16, width of `cfg_delay` and the delay count.
- LENGTH_WIDTH, 16, width of `cfg_length`, `sample_index` and the capture count.
- HOLDOFF, 15, clock cycles spent in HOLDOFF after a capture; 0 = return directly to IDLE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cfg_delay  in  DELAY_WIDTH  samples to skip after trigger; sampled on accepted arm
- cfg_length  in  LENGTH_WIDTH  samples to capture; sampled on accepted arm
- arm  in  1  request arming; honoured only in IDLE
- trigger  in  1  start event; honoured only in ARMED
- abort  in  1  return to IDLE next cycle
- s_valid  in  1  one-cycle sample strobe from the datapath
- capture_en  out  1  write enable to the buffer
- sample_index  out  LENGTH_WIDTH  write address for the current captured sample
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse marking capture completion
- state  out  3  current state encoding, for status readback

Behaviour:
- Reset (async assert, release on clk edge) puts every output low or zero:
  - state = IDLE, capture_en = 0, sample_index = 0, busy = 0, done = 0.
  - Latched config cleared to 0; all counters 0.
- States: IDLE = 0, ARMED = 1, DELAY = 2, CAPTURE = 3, HOLDOFF = 4. Codes 5–7 are illegal and recover to IDLE on the next edge.
- Priority each cycle: rst > abort > normal transitions.
- abort in any state goes to IDLE on the next edge:
  - No done pulse; counters cleared.
  - An abort while IDLE is a no-op.
- IDLE:
  - arm=1 with `cfg_length` != 0 latches `cfg_delay`/`cfg_length` and moves to ARMED.
  - arm=1 with `cfg_length` == 0 is ignored and the block stays IDLE.
  - trigger is ignored in IDLE.
- ARMED:
  - trigger=1 moves to DELAY if the latched delay != 0, otherwise directly to CAPTURE.
  - Further arm is ignored.
  - Sample strobes in the trigger cycle are not counted.
- DELAY:
  - The sample counter increments on each s_valid.
  - On the s_valid where count == delay-1, go to CAPTURE with the counter cleared to 0.
  - Exactly `delay` strobes are skipped.
- CAPTURE:
  - capture_en = (state==CAPTURE) & s_valid, decoded combinationally from the registered state. This gives same-cycle alignment with the sample.
  - sample_index = current count. The count increments after each captured strobe.
  - On the s_valid where count == length-1, that sample is written, then go to HOLDOFF (or IDLE if HOLDOFF==0).
  - done is registered high for the following cycle only.
- HOLDOFF:
  - Counts HOLDOFF clock cycles, independent of s_valid, then returns to IDLE.
  - arm and trigger are ignored.
- busy = (state != IDLE), registered from state.
- A second trigger during DELAY or CAPTURE is ignored and does not restart the window.
- Counter widths never wrap in normal operation: length is bounded to `2^LENGTH_WIDTH-1`, and the compare terminates the count first.
- Gaps in s_valid of any length are legal and simply stall DELAY/CAPTURE progress.

Decomposition:
- Shared header `capture_seq_defs.vh`: state encodings (S_IDLE…S_HOLDOFF) and the state-field width 3. The register map and readback logic include it too.
- One natural sub-module, `seq_count`: an up-counter with sync clear, enable and a terminal-compare flag against a runtime limit, parameterised by width.
  - Instanced twice: the sample counter (shared by DELAY and CAPTURE, cleared on entry to each) and the holdoff counter.
- `func_log2.vh` is used where width derivation is needed.

Test Plan:
- Basic capture, delay 0:
  - Stimulus: rst; arm with cfg_length=4, cfg_delay=0; trigger; s_valid every cycle.
  - Response: capture_en high exactly 4 cycles with sample_index 0,1,2,3; done pulses 1 cycle after index 3; busy stays high for 15 HOLDOFF cycles, then falls.
- Delayed capture with gaps:
  - Stimulus: delay=3, length=2; s_valid every other cycle.
  - Response: first 3 strobes after trigger are not captured; the 4th and 5th strobes give capture_en with indices 0 and 1; done follows the 5th strobe.
- Abort mid-capture:
  - Stimulus: length=8; abort asserted after index 2.
  - Response: IDLE next edge; no done; capture_en low; a new arm plus trigger restarts at index 0.
- Ignored events:
  - Stimulus: trigger in IDLE; arm with length=0; arm during CAPTURE; trigger during HOLDOFF.
  - Response: state unchanged by each event; no capture_en.
- Async reset mid-DELAY:
  - Stimulus: rst asserted between clock edges during DELAY.
  - Response: all outputs 0 immediately; state reads 0 before the next edge.
- Simultaneous abort+trigger in ARMED, and HOLDOFF=0 build:
  - Response: abort wins (IDLE); with HOLDOFF=0, state goes CAPTURE→IDLE directly with done still pulsing.
